// File: rtl/permutation_ctrl_if.sv
// Handshake bundle between the Ascon mode FSM (master) and the permutation controller (slave).
// abort_i exists only when PERM_CTRL_ABORT_EN is defined.
interface permutation_ctrl_if;
  logic       start_i;
  logic       mode_i;
`ifdef PERM_CTRL_ABORT_EN
  logic       abort_i;
`endif
  logic [3:0] round_o;
  logic       input_select_o;
  logic       ena_reg_state_o;
  logic       busy_o;
  logic       done_o;

`ifdef PERM_CTRL_ABORT_EN
  modport master (output start_i, mode_i, abort_i,
                  input  round_o, input_select_o, ena_reg_state_o, busy_o, done_o);
  modport slave  (input  start_i, mode_i, abort_i,
                  output round_o, input_select_o, ena_reg_state_o, busy_o, done_o);
`else
  modport master (output start_i, mode_i,
                  input  round_o, input_select_o, ena_reg_state_o, busy_o, done_o);
  modport slave  (input  start_i, mode_i,
                  output round_o, input_select_o, ena_reg_state_o, busy_o, done_o);
`endif
endinterface

// File: rtl/permutation_ctrl.sv
// Ascon permutation sequencer: runs p^a (12 rounds) or p^b (ROUNDS_B rounds) on start.
// Optional abort support is enabled by defining PERM_CTRL_ABORT_EN.
module permutation_ctrl #(
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic               clock_i,
  input  logic               reset_i,
  permutation_ctrl_if.slave  perm
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     state_q;
  logic [3:0] rc_q;
  logic [3:0] start_round;
  logic       abort;

  always_comb begin
    start_round = perm.mode_i ? START_B : 4'd0;
  end

  always_comb begin
`ifdef PERM_CTRL_ABORT_EN
    abort = perm.abort_i;
`else
    abort = 1'b0;
`endif
  end

  // Outputs are registered alongside the next state so they always equal the
  // Moore decode of (state_q, rc_q) without a combinational path from inputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q              <= IDLE;
      rc_q                 <= '0;
      perm.round_o         <= '0;
      perm.input_select_o  <= 1'b0;
      perm.ena_reg_state_o <= 1'b0;
      perm.busy_o          <= 1'b0;
      perm.done_o          <= 1'b0;
    end else begin
      perm.round_o         <= '0;
      perm.input_select_o  <= 1'b0;
      perm.ena_reg_state_o <= 1'b0;
      perm.busy_o          <= 1'b0;
      perm.done_o          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (perm.start_i) begin
            state_q              <= LOAD;
            rc_q                 <= start_round;
            perm.round_o         <= start_round;
            perm.ena_reg_state_o <= 1'b1;
            perm.busy_o          <= 1'b1;
          end
        end
        LOAD, RUN: begin
          if (abort) begin
            state_q <= IDLE;
            rc_q    <= '0;
          end else if (rc_q == LAST_ROUND) begin
            state_q             <= DONE;
            perm.done_o         <= 1'b1;
            perm.input_select_o <= 1'b1;
          end else begin
            state_q              <= RUN;
            rc_q                 <= rc_q + 4'd1;
            perm.round_o         <= rc_q + 4'd1;
            perm.input_select_o  <= 1'b1;
            perm.ena_reg_state_o <= 1'b1;
            perm.busy_o          <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rc_q    <= '0;
        end
        default: begin
          state_q <= IDLE;
          rc_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Randomized bench for permutation_ctrl with ROUNDS_B=6 and ROUNDS_B=8 instances in parallel.
// Reference model tracks each operation as (active, cycle index k, round count n).
module tb_permutation_ctrl;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic start_drv = 1'b0;
  logic mode_drv  = 1'b0;
  logic abort_drv = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock_i = ~clock_i;

  permutation_ctrl_if if6 ();
  permutation_ctrl_if if8 ();

  assign if6.start_i = start_drv;
  assign if6.mode_i  = mode_drv;
  assign if8.start_i = start_drv;
  assign if8.mode_i  = mode_drv;
`ifdef PERM_CTRL_ABORT_EN
  assign if6.abort_i = abort_drv;
  assign if8.abort_i = abort_drv;
`endif

  permutation_ctrl #(.ROUNDS_B(6)) dut6 (.clock_i(clock_i), .reset_i(reset_i), .perm(if6));
  permutation_ctrl #(.ROUNDS_B(8)) dut8 (.clock_i(clock_i), .reset_i(reset_i), .perm(if8));

  // Model state per instance: index 0 -> ROUNDS_B=6, index 1 -> ROUNDS_B=8
  int unsigned nb [2] = '{6, 8};
  bit          active [2];
  int unsigned k [2];
  int unsigned n [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) active[d] = 1'b0;
  endtask

  // Called once per rising edge with the inputs that the DUT sampled at that edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (reset_i) begin
        active[d] = 1'b0;
      end else if (active[d]) begin
        if (abort_drv && k[d] <= n[d]) active[d] = 1'b0;
        else begin
          k[d]++;
          if (k[d] > n[d] + 1) active[d] = 1'b0;
        end
      end else if (start_drv) begin
        active[d] = 1'b1;
        k[d] = 1;
        n[d] = mode_drv ? nb[d] : 12;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] rnd [2];
    logic       sel [2], ena [2], bsy [2], dn [2];
    string      name;
    rnd[0] = if6.round_o; sel[0] = if6.input_select_o; ena[0] = if6.ena_reg_state_o;
    bsy[0] = if6.busy_o;  dn[0]  = if6.done_o;
    rnd[1] = if8.round_o; sel[1] = if8.input_select_o; ena[1] = if8.ena_reg_state_o;
    bsy[1] = if8.busy_o;  dn[1]  = if8.done_o;
    for (int d = 0; d < 2; d++) begin
      bit running, finished;
      name = (d == 0) ? "rb6" : "rb8";
      running  = active[d] && k[d] <= n[d];
      finished = active[d] && k[d] == n[d] + 1;
      check_eq({name, "_ena"},  32'(ena[d]), 32'(running));
      check_eq({name, "_busy"}, 32'(bsy[d]), 32'(running));
      check_eq({name, "_done"}, 32'(dn[d]),  32'(finished));
      check_eq({name, "_sel"},  32'(sel[d]), 32'((running && k[d] > 1) || finished));
      if (running)
        check_eq({name, "_round"}, 32'(rnd[d]), 12 - n[d] + k[d] - 1);
      else if (!finished)
        check_eq({name, "_round_idle"}, 32'(rnd[d]), 0);
    end
  endtask

  task automatic cycle();
    @(posedge clock_i);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    bit found;
    model_reset();
    // Reset state
    repeat (3) cycle();
    reset_i = 1'b0;

    // Single p^a then single p^b
    start_drv = 1'b1; mode_drv = 1'b0;
    cycle();
    start_drv = 1'b0; mode_drv = 1'b1;
    repeat (16) cycle();
    start_drv = 1'b1; mode_drv = 1'b1;
    cycle();
    start_drv = 1'b0; mode_drv = 1'b0;
    repeat (12) cycle();

    // start held high: back-to-back spacing N+2
    start_drv = 1'b1;
    for (int i = 0; i < 60; i++) begin
      mode_drv = (i < 30) ? 1'b0 : 1'b1;
      cycle();
    end
    start_drv = 1'b0;
    repeat (16) cycle();

    // Random start/mode pulses, ignored while busy
    for (int i = 0; i < 400; i++) begin
      start_drv = ($urandom_range(3) == 0);
      mode_drv  = $urandom_range(1);
      cycle();
    end
    start_drv = 1'b0;
    repeat (16) cycle();

    // Reset in the middle of p^a at round 5
    start_drv = 1'b1; mode_drv = 1'b0;
    cycle();
    start_drv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (active[0] && k[0] == 6) found = 1'b1;
      else cycle();
    end
    check_eq("reach_round5", 32'(found), 1);
    #2 reset_i = 1'b1;
    model_reset();
    #1 check_outputs();
    cycle();
    reset_i = 1'b0;
    cycle();
    start_drv = 1'b1; mode_drv = 1'b0;
    cycle();
    start_drv = 1'b0;
    repeat (16) cycle();

`ifdef PERM_CTRL_ABORT_EN
    // Abort at round 3 of p^a, then abort together with start in IDLE
    start_drv = 1'b1; mode_drv = 1'b0;
    cycle();
    start_drv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (active[0] && k[0] == 4) found = 1'b1;
      else cycle();
    end
    check_eq("reach_round3", 32'(found), 1);
    abort_drv = 1'b1;
    cycle();
    abort_drv = 1'b0;
    repeat (16) cycle();
    start_drv = 1'b1; abort_drv = 1'b1; mode_drv = 1'b1;
    cycle();
    start_drv = 1'b0; abort_drv = 1'b0;
    repeat (14) cycle();
    for (int i = 0; i < 300; i++) begin
      start_drv = ($urandom_range(3) == 0);
      mode_drv  = $urandom_range(1);
      abort_drv = ($urandom_range(15) == 0);
      cycle();
    end
    start_drv = 1'b0; abort_drv = 1'b0;
    repeat (16) cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/permutation_ctrl.md
# permutation_ctrl

Sequencing controller for the Ascon permutation datapath: constant addition, substitution layer, diffusion layer, and the state register with its input mux. On a start request it runs either p^a (12 rounds) or p^b (ROUNDS_B rounds). It drives the datapath's round index, input-mux select and state-register enable cycle by cycle, and reports completion with a one-cycle done pulse. It sits between the Ascon mode FSM (initialisation / associated data / plaintext / finalisation) and the permutation datapath.

## Interface
Parameters:
- ROUNDS_B, default 6: rounds executed for p^b. Legal range 1..12 (Ascon-128 uses 6, Ascon-128a uses 8).

Ports:
- clock_i  in  1  single system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a permutation; sampled only in IDLE.
- mode_i  in  1  sampled with start_i: 0 = p^a (12 rounds), 1 = p^b (ROUNDS_B rounds).
- round_o  out  4  round index to the constant-add stage (0..11).
- input_select_o  out  1  0 = datapath takes the external state, 1 = datapath takes the state-register output.
- ena_reg_state_o  out  1  state-register write enable.
- busy_o  out  1  high from the LOAD state through the last round.
- done_o  out  1  one-cycle pulse once the final round's result is in the state register.
- abort_i  in  1  present only with PERM_CTRL_ABORT_EN.

## Operation
- The start round is 0 for p^a and 12-ROUNDS_B for p^b. The last round is always 11.
- FSM states:
  - IDLE: all outputs 0. If start_i=1, latch the start round into round counter rc_q and go to LOAD. Otherwise stay.
  - LOAD: input_select_o=0, ena_reg_state_o=1, busy_o=1, round_o=rc_q. The first round is computed from the external state. If rc_q==11, go to DONE. Otherwise rc_q++ and go to RUN.
  - RUN: input_select_o=1, ena_reg_state_o=1, busy_o=1, round_o=rc_q. If rc_q==11, go to DONE. Otherwise rc_q++.
  - DONE: done_o=1, ena_reg_state_o=0, input_select_o=1 (the register output stays visible), busy_o=0. Go to IDLE unconditionally.
- All outputs are Moore outputs decoded from state and rc_q; none depend combinationally on inputs.
- rc_q is 4 bits and never exceeds 11; no wrap-around is possible.
- start_i outside IDLE is ignored; it is not queued. mode_i is ignored except in the cycle start_i is accepted.
- Reset, including in the middle of an operation: the FSM goes to IDLE immediately, rc_q=0, and all outputs are 0. No done_o is issued for the interrupted operation.
- Reset values: round_o=0, input_select_o=0, ena_reg_state_o=0, busy_o=0, done_o=0.

## Timing
- Start accepted in cycle T. LOAD occupies cycle T+1. Rounds occupy cycles T+1 .. T+N, where N=12 for p^a and N=ROUNDS_B for p^b. done_o is high in cycle T+N+1.
- Resulting latencies from start to done: p^a = 13 cycles; p^b with ROUNDS_B=6 is 7 cycles, with ROUNDS_B=8 is 9 cycles.
- ena_reg_state_o is high for exactly N consecutive cycles per operation.
- Back-to-back operation: start_i may be asserted during the DONE cycle, but it is only accepted in IDLE. The minimum start-to-start spacing is therefore N+2 cycles.
- The result is stable in the state register from cycle T+N+1 until the next LOAD.

## Configuration
- PERM_CTRL_ABORT_EN:
  - Defined: the abort_i port exists. abort_i=1 in LOAD or RUN sends the FSM to IDLE on the next edge. ena_reg_state_o drops in that next cycle, no done_o is issued, and rc_q is cleared. In IDLE or DONE, abort_i has no effect; start_i and abort_i together in IDLE start normally.
  - Undefined: the abort_i port is absent and operations always run to completion.

## Test plan
- Reset asserted mid-RUN (p^a, round 5) -> outputs 0 in the same cycle; after release the FSM is in IDLE and start_i then produces a normal 13-cycle p^a.
- start_i=1, mode_i=0 -> round_o sequence 0,1,…,11; input_select_o=0 only on round 0; ena_reg_state_o high for 12 cycles; done_o at T+13. The datapath result matches the known-answer p12 vector.
- start_i=1, mode_i=1, ROUNDS_B=6 -> round_o 6..11; done_o at T+7. Repeat with ROUNDS_B=8 -> round_o 4..11; done_o at T+9.
- start_i held high continuously -> accepted only in IDLE; operations spaced exactly N+2 cycles apart; no overlapping ena_reg_state_o windows.
- start_i pulsed during RUN with mode_i toggled -> ignored; the current operation's round sequence is unchanged.
- With PERM_CTRL_ABORT_EN: abort_i at round 3 of p^a -> ena_reg_state_o=0 on the next cycle; no done_o; a following start_i runs normally. abort_i together with start_i in IDLE -> the operation starts.
